// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I pipeline: datapath width, ALU op codes
// and forward-mux select codes used by the execute stage.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // ALU operation codes as programmed by decode
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // Forward select codes driven by the hazard unit (11 falls back to RF)
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the execute stage; Zero feeds beq resolution.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero
);

    localparam int SHW = $clog2(XLEN);

    // Only the low shift-amount bits of SrcB are significant
    logic [SHW-1:0] shamt;
    assign shamt = SrcB[SHW-1:0];

    // Operation select; arithmetic wraps, no overflow detection
    always_comb begin
        ALUResult = '0;
        case (ALUControl)
            ALU_ADD: ALUResult = SrcA + SrcB;
            ALU_SUB: ALUResult = SrcA - SrcB;
            ALU_AND: ALUResult = SrcA & SrcB;
            ALU_OR:  ALUResult = SrcA | SrcB;
            ALU_XOR: ALUResult = SrcA ^ SrcB;
            ALU_SLT: ALUResult = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_SLL: ALUResult = SrcA << shamt;
            ALU_SRL: ALUResult = SrcA >> shamt;
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch/jump redirect and the
// E/M pipeline register feeding the memory stage.
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            jalrE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [1:0]      ResultSrcE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ALUResultM_in,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] write_data_e;
    logic [XLEN-1:0] alu_result_e;
    logic            zero_e;
    logic [XLEN-1:0] jalr_sum;

    // Forward muxes; the unused select code falls back to the register file value
    always_comb begin
        case (ForwardAE)
            FWD_W:   src_a = ResultW;
            FWD_M:   src_a = ALUResultM_in;
            default: src_a = RD1_E;
        endcase
        case (ForwardBE)
            FWD_W:   write_data_e = ResultW;
            FWD_M:   write_data_e = ALUResultM_in;
            default: write_data_e = RD2_E;
        endcase
        src_b = ALUSrcE ? ImmExtE : write_data_e;
    end

    alu #(.XLEN(XLEN)) u_alu (
        .SrcA       (src_a),
        .SrcB       (src_b),
        .ALUControl (ALUControlE),
        .ALUResult  (alu_result_e),
        .Zero       (zero_e)
    );

    // Redirect: jalr uses the forwarded rs1 with bit 0 cleared, others are PC-relative
    always_comb begin
        jalr_sum  = src_a + ImmExtE;
        PCTargetE = jalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);
        PCSrcE    = JumpE | jalrE | (BranchE & zero_e);
    end

    // E/M register state
    logic [XLEN-1:0] alu_result_m_q, alu_result_m_d;
    logic [XLEN-1:0] write_data_m_q, write_data_m_d;
    logic [XLEN-1:0] pc_plus4_m_q,   pc_plus4_m_d;
    logic [4:0]      rd_m_q,         rd_m_d;
    logic            reg_write_m_q,  reg_write_m_d;
    logic            mem_write_m_q,  mem_write_m_d;
    logic [1:0]      result_src_m_q, result_src_m_d;

    // Next-state of the E/M register: loads every cycle, no stall path
    always_comb begin
        alu_result_m_d = alu_result_e;
        write_data_m_d = write_data_e;
        pc_plus4_m_d   = PCPlus4E;
        rd_m_d         = RdE;
        reg_write_m_d  = RegWriteE;
        mem_write_m_d  = MemWriteE;
        result_src_m_d = ResultSrcE;
    end

    // E/M register; reset discards the instruction currently in E
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_m_q <= '0;
            write_data_m_q <= '0;
            pc_plus4_m_q   <= '0;
            rd_m_q         <= '0;
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            result_src_m_q <= '0;
        end else begin
            alu_result_m_q <= alu_result_m_d;
            write_data_m_q <= write_data_m_d;
            pc_plus4_m_q   <= pc_plus4_m_d;
            rd_m_q         <= rd_m_d;
            reg_write_m_q  <= reg_write_m_d;
            mem_write_m_q  <= mem_write_m_d;
            result_src_m_q <= result_src_m_d;
        end
    end

    assign ALUResultM = alu_result_m_q;
    assign WriteDataM = write_data_m_q;
    assign PCPlus4M   = pc_plus4_m_q;
    assign RdM        = rd_m_q;
    assign RegWriteM  = reg_write_m_q;
    assign MemWriteM  = mem_write_m_q;
    assign ResultSrcM = result_src_m_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: a recorder pushes the expected E/M
// contents at each capture edge, a monitor pops and compares on the next
// falling edge; redirect outputs are checked combinationally by the driver.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [31:0] ALUResultM_in, ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
    } m_t;

    m_t sb_q[$];

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .jalrE(jalrE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .ResultSrcE(ResultSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUResultM_in(ALUResultM_in), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                         input logic [31:0] w, input logic [31:0] m);
        if (sel == 2'd1) return w;
        if (sel == 2'd2) return m;
        return rf;
    endfunction

    function automatic logic [31:0] calc(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd6: return a << sh;
            default: return a >> sh;
        endcase
    endfunction

    function automatic logic [31:0] model_a();
        return pick(ForwardAE, RD1_E, ResultW, ALUResultM_in);
    endfunction

    function automatic logic [31:0] model_wd();
        return pick(ForwardBE, RD2_E, ResultW, ALUResultM_in);
    endfunction

    function automatic logic [31:0] model_alu();
        return calc(ALUControlE, model_a(), ALUSrcE ? ImmExtE : model_wd());
    endfunction

    // ---------------- recorder: expected E/M contents at each capture edge ----------------
    always @(posedge clk) begin
        m_t e;
        if (rst) begin
            e = '{alu: 32'd0, wd: 32'd0, pc4: 32'd0, rd: 5'd0, rw: 1'b0, mw: 1'b0, rs: 2'd0};
        end else begin
            e = '{alu: model_alu(), wd: model_wd(), pc4: PCPlus4E, rd: RdE,
                  rw: RegWriteE, mw: MemWriteE, rs: ResultSrcE};
        end
        sb_q.push_back(e);
    end

    // ---------------- monitor: compare registered outputs ----------------
    always @(negedge clk) begin
        m_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            txn++;
            if (ALUResultM !== e.alu || WriteDataM !== e.wd || PCPlus4M !== e.pc4 ||
                RdM !== e.rd || RegWriteM !== e.rw || MemWriteM !== e.mw ||
                ResultSrcM !== e.rs) begin
                bad++;
                $display("FAIL em_reg txn=%0d got alu=%h wd=%h pc4=%h rd=%0d rw=%b mw=%b rs=%0d want alu=%h wd=%h pc4=%h rd=%0d rw=%b mw=%b rs=%0d",
                         txn, ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM,
                         e.alu, e.wd, e.pc4, e.rd, e.rw, e.mw, e.rs);
            end else begin
                $display("txn %0d ok alu=%h wd=%h pc4=%h rd=%0d", txn, e.alu, e.wd, e.pc4, e.rd);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic bubble();
        RD1_E = 0; RD2_E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0; RdE = 0;
        RegWriteE = 0; MemWriteE = 0; JumpE = 0; jalrE = 0; BranchE = 0; ALUSrcE = 0;
        ALUControlE = 0; ResultSrcE = 0; ForwardAE = 0; ForwardBE = 0;
        ALUResultM_in = 0; ResultW = 0;
    endtask

    // Check the combinational redirect, then let one capture edge pass
    task automatic cycle(input string name);
        logic        exp_src;
        logic [31:0] exp_tgt;
        logic [31:0] s;
        #1;
        s       = model_a() + ImmExtE;
        exp_tgt = jalrE ? (s & 32'hFFFF_FFFE) : (PCE + ImmExtE);
        exp_src = JumpE | jalrE | (BranchE & (model_alu() == 32'd0));
        total++;
        if (PCSrcE !== exp_src || PCTargetE !== exp_tgt) begin
            bad++;
            $display("FAIL redirect_%s got src=%b tgt=%h want src=%b tgt=%h",
                     name, PCSrcE, PCTargetE, exp_src, exp_tgt);
        end
        @(negedge clk);
    endtask

    task automatic rr(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [4:0] rd);
        bubble();
        RD1_E = a; RD2_E = b; ALUControlE = op; RdE = rd; RegWriteE = 1;
        PCE = 32'h400; PCPlus4E = 32'h404;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bubble();
        rst = 1'b1;
        @(negedge clk);
        // reset with junk inputs: outputs must stay zero
        RD1_E = 32'hDEAD_BEEF; RD2_E = 32'h1234_5678; RdE = 5'd9; RegWriteE = 1; MemWriteE = 1;
        PCPlus4E = 32'h44; ResultSrcE = 2'd2;
        cycle("reset_junk");
        cycle("reset_junk2");
        rst = 1'b0;

        // add / sub / slt
        rr(32'd5, 32'd7, 3'd0, 5'd1);              cycle("add");
        rr(32'd5, 32'd7, 3'd1, 5'd2);              cycle("sub");
        rr(32'd5, 32'd7, 3'd5, 5'd3);              cycle("slt");
        rr(32'hFFFF_FFFF, 32'd1, 3'd5, 5'd4);      cycle("slt_neg");
        rr(32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd2, 5'd5); cycle("and");
        rr(32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd3, 5'd6); cycle("or");
        rr(32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd4, 5'd7); cycle("xor");

        // forwarding
        rr(32'd1, 32'd0, 3'd0, 5'd8);
        ALUResultM_in = 32'h40; ResultW = 32'h80; ImmExtE = 32'd4; ALUSrcE = 1;
        ForwardAE = 2'b10;                          cycle("fwd_a_m");
        ForwardAE = 2'b01;                          cycle("fwd_a_w");
        ForwardAE = 2'b11;                          cycle("fwd_a_illegal");
        ForwardAE = 2'b00; ForwardBE = 2'b10; MemWriteE = 1; RegWriteE = 0; cycle("fwd_b_m");
        ForwardBE = 2'b01;                          cycle("fwd_b_w");

        // branch taken / not taken
        bubble(); BranchE = 1; ALUControlE = 3'd1; RD1_E = 9; RD2_E = 9;
        PCE = 32'h100; PCPlus4E = 32'h104; ImmExtE = 32'hFFFF_FFF8; cycle("beq_taken");
        RD2_E = 8;                                  cycle("beq_not_taken");

        // jal / jalr
        bubble(); JumpE = 1; PCE = 32'h20; PCPlus4E = 32'h24; ImmExtE = 32'h10;
        RegWriteE = 1; RdE = 5'd1; ResultSrcE = 2'd2; cycle("jal");
        bubble(); jalrE = 1; ForwardAE = 2'b10; ALUResultM_in = 32'h1003; ImmExtE = 0;
        ALUSrcE = 1; PCE = 32'h80; PCPlus4E = 32'h84; cycle("jalr");

        // shifts use only SrcB[4:0]
        rr(32'h8000_0001, 32'h21, 3'd6, 5'd10);    cycle("sll");
        rr(32'h8000_0001, 32'h21, 3'd7, 5'd11);    cycle("srl");

        // reset mid-operation, then a normal instruction
        rr(32'h55, 32'd0, 3'd0, 5'd5);             cycle("load_before_rst");
        rst = 1'b1;                                 cycle("mid_rst");
        rst = 1'b0;
        rr(32'h10, 32'h3, 3'd0, 5'd12);            cycle("after_rst");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            RD1_E = $urandom; RD2_E = $urandom; ImmExtE = $urandom; PCE = $urandom;
            PCPlus4E = PCE + 4; RdE = 5'($urandom); ALUControlE = 3'($urandom);
            ResultSrcE = 2'($urandom); ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            ALUResultM_in = $urandom; ResultW = $urandom;
            RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ALUSrcE = 1'($urandom);
            JumpE = ($urandom_range(0, 7) == 0); jalrE = ($urandom_range(0, 7) == 0);
            BranchE = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                RD2_E = RD1_E; ForwardBE = ForwardAE; ALUSrcE = 0; ALUControlE = 3'd1;
            end
            rst = ($urandom_range(0, 19) == 0);
            cycle("random");
        end
        rst = 1'b0;
        bubble();
        cycle("drain");
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
